// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always whole words; low byte-offset bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory channel between the fetch unit (master) and memory (slave).
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both high; while valid is high and ready is low the
// address is held. Responses come back in request order, one per
// imem_rsp_valid cycle, and cannot be back-pressured.
interface fetch_if;

  logic                         imem_req_valid;
  logic                         imem_req_ready;
  logic [fetch_pkg::ADDR_W-1:0] imem_req_addr;
  logic                         imem_rsp_valid;
  logic [fetch_pkg::INSTR_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries: synchronous push/pop/clear,
// registered count. Push and pop together keep the count unchanged, also
// when full (slot is recycled) or empty (push data bypasses to head).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);
  assign head    = empty ? push_data : mem[rd_ptr];

  // Storage write; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order word requests with credit-based
// flow control, prefetch FIFO and IF/ID register with stall and redirect.
// Optional feature macro: FETCH_BUBBLE_CNT_EN adds the bubble_cnt counter/port.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_if.master            imem,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_stall,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]        bubble_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;       // pc tag of the next response kept
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_sum;
  logic              fifo_full;
  logic              fifo_empty;
  logic              req_fire;
  logic              rsp_keep;
  logic              fifo_pop;
  fetch_entry_t      fifo_head;
  fetch_entry_t      fifo_in;

  // Credits come from registered state only, so every accepted request is
  // guaranteed a FIFO slot when its response returns.
  assign credit_sum          = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem.imem_req_valid = rst_n && !redirect_valid && !fifo_full &&
                               (credit_sum < DEPTH_LIM);
  assign imem.imem_req_addr  = pc;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

  assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem.imem_rsp_valid);

  // A response in a redirect cycle belongs to the flushed stream.
  assign rsp_keep       = imem.imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign fifo_in.pc     = rsp_pc;
  assign fifo_in.instr  = imem.imem_rsp_data;
  assign fifo_pop       = !redirect_valid && !id_stall && !fifo_empty;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (rsp_keep),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Fetch pc, response tag, in-flight and discard bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc     <= word_align(redirect_pc);
        rsp_pc <= word_align(redirect_pc);
        drop   <= outstanding_next;
      end else begin
        if (req_fire) pc <= pc + PC_STEP;
        if (imem.imem_rsp_valid) begin
          if (drop != '0) drop <= drop - CNT_W'(1);
          else            rsp_pc <= rsp_pc + PC_STEP;
        end
      end
    end
  end

  // IF/ID register: redirect kills it, stall holds it, otherwise load or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (redirect_valid) begin
      ifid_valid <= 1'b0;
    end else if (!id_stall) begin
      if (!fifo_empty) begin
        ifid_valid <= 1'b1;
        ifid_instr <= fifo_head.instr;
        ifid_pc    <= fifo_head.pc;
      end else begin
        ifid_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_q;

  // Count unstalled cycles in which decode sees no instruction; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
    end else if (!ifid_valid && !id_stall && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table for the
// 1-cycle memory run (stall, redirect, pc wrap), then hand sequences for
// slow/toggling memory, redirect drops, mid-run reset and bubble_cnt.
module tb_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus ();

  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc)
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    .bubble_cnt     (bubble_cnt)
`endif
  );

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  // ---------------- bench state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          ready_toggle = 1'b0;
  bit          sb_en = 1'b0;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_pc = '0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_addr = '0;
  bit          last_stall = 1'b0;
  int          shown = 0;
  logic [31:0] first_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Assert reset at a negedge, check cleared outputs, release two cycles later.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    id_stall = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    mem_q.delete();
    exp_q.delete();
    exp_req_pc = 32'h0;
    hold_prev = 1'b0;
    last_stall = 1'b0;
    #1;
    check("rst_req_valid", bus.imem_req_valid, 32'd0);
    check("rst_ifid_valid", ifid_valid, 32'd0);
    check("rst_ifid_pc", ifid_pc, 32'd0);
    check("rst_ifid_instr", ifid_instr, 32'd0);
`ifdef FETCH_BUBBLE_CNT_EN
    check("rst_bubble_cnt", bubble_cnt, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Drive one cycle's inputs (memory model included) and do per-cycle checks.
  task automatic drive_cycle(input logic stall, input logic redir, input logic [31:0] rpc);
    mreq_t       m;
    logic [31:0] e;
    id_stall = stall;
    redirect_valid = redir;
    redirect_pc = rpc;
    bus.imem_req_ready = ready_toggle ? ((cyc % 3) != 2) : 1'b1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = mem_q[0].addr ^ XOR_KEY;
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = '0;
    end
    #1;
    if (hold_prev && !redir) begin
      check("req_valid_held", bus.imem_req_valid, 32'd1);
      check("req_addr_held", bus.imem_req_addr, hold_addr);
    end
    if (sb_en) begin
      if (redir) check("req_valid_in_redirect", bus.imem_req_valid, 32'd0);
      if (ifid_valid && !last_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ifid_unexpected: got pc %h expected no instruction (cycle %0d)", ifid_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          if (shown == 0) first_pc = ifid_pc;
          check("sb_ifid_pc", ifid_pc, e);
          check("sb_ifid_instr", ifid_instr, e ^ XOR_KEY);
          shown++;
        end
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("req_addr_order", bus.imem_req_addr, exp_req_pc);
      m.addr = bus.imem_req_addr;
      m.due = cyc + lat;
      mem_q.push_back(m);
      if (sb_en) exp_q.push_back(exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
    end
    hold_prev = bus.imem_req_valid && !bus.imem_req_ready;
    hold_addr = bus.imem_req_addr;
    last_stall = stall;
    if (redir) begin
      exp_q.delete();
      exp_req_pc = {rpc[31:2], 2'b00};
    end
    if (sb_en) begin
      checks++;
      if (mem_q.size() > 4) begin
        errors++;
        $display("FAIL inflight_bound: got %0d expected at most 4 (cycle %0d)", mem_q.size(), cyc);
      end
      check("fifo_count_bound", 32'(dut.u_fifo.count > 3'd4), 32'd0);
    end
  endtask

  task automatic finish_cycle();
    cyc++;
    @(negedge clk);
  endtask

  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc);
    drive_cycle(stall, redir, rpc);
    finish_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_ifid_valid;
    logic [31:0] exp_ifid_pc;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  // Watchdog: every wait is bounded anyway, this guards against a stuck clock.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit found;
    // 1-cycle memory, always ready. Stall cycles 5-8, redirect with stall
    // and a response in cycle 15, redirect near the top of memory in cycle 20.
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 1'b1, 32'h0000_0008};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0018, 1'b1, 32'h0000_0008};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0008};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0008};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0008};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_001C, 1'b1, 32'h0000_000C};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0020, 1'b1, 32'h0000_0010};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0024, 1'b1, 32'h0000_0014};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0028, 1'b1, 32'h0000_0018};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_002C, 1'b1, 32'h0000_001C};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         1'b1, 32'h0000_0020};
    vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b0, 32'h0};
    vecs[19] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_010C, 1'b1, 32'h0000_0100};
    vecs[20] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 1'b0, 32'h0,         1'b1, 32'h0000_0104};
    vecs[21] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    vecs[22] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[23] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[24] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFF8};
    vecs[25] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'hFFFF_FFFC};
    vecs[26] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000};
    vecs[27] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004};

    @(negedge clk);
    do_reset();
    lat = 1;
    ready_toggle = 1'b0;
    sb_en = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive_cycle(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      check($sformatf("v%0d_req_valid", i), bus.imem_req_valid, vecs[i].exp_req_valid);
      if (vecs[i].exp_req_valid) check($sformatf("v%0d_req_addr", i), bus.imem_req_addr, vecs[i].exp_req_addr);
      check($sformatf("v%0d_ifid_valid", i), ifid_valid, vecs[i].exp_ifid_valid);
      if (vecs[i].exp_ifid_valid) begin
        check($sformatf("v%0d_ifid_pc", i), ifid_pc, vecs[i].exp_ifid_pc);
        check($sformatf("v%0d_ifid_instr", i), ifid_instr, vecs[i].exp_ifid_pc ^ XOR_KEY);
      end
`ifdef FETCH_BUBBLE_CNT_EN
      if (i == 3) check("bubble_cnt_first_instr", bubble_cnt, 32'd3);
`endif
      finish_cycle();
    end

    // Mid-run reset, then 3-cycle memory with ready low every third cycle.
    do_reset();
    lat = 3;
    ready_toggle = 1'b1;
    sb_en = 1'b1;
    shown = 0;
    repeat (15) step(1'b0, 1'b0, 32'h0);
    check("slow_mem_progress", 32'(shown >= 3), 32'd1);

    // Redirect to 0x40 while exactly two requests are in flight.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mem_q.size() == 2) begin
        found = 1'b1;
        step(1'b0, 1'b1, 32'h0000_0040);
      end else begin
        step(1'b0, 1'b0, 32'h0);
      end
    end
    check("redirect_two_outstanding_found", 32'(found), 32'd1);
    shown = 0;
    for (int j = 1; j <= 3; j++) begin
      drive_cycle(1'b0, 1'b0, 32'h0);
      check($sformatf("ifid_valid_R+%0d", j), ifid_valid, 32'd0);
      finish_cycle();
    end
    repeat (25) step(1'b0, 1'b0, 32'h0);
    check("first_pc_after_redirect", first_pc, 32'h0000_0040);
    check("redirect_progress", 32'(shown >= 8), 32'd1);

    // Redirect with two in flight, then reset right away: pending drops must vanish.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mem_q.size() == 2) begin
        found = 1'b1;
        step(1'b0, 1'b1, 32'h0000_0080);
      end else begin
        step(1'b0, 1'b0, 32'h0);
      end
    end
    check("redirect_before_reset_found", 32'(found), 32'd1);
    do_reset();
    lat = 1;
    ready_toggle = 1'b0;
    shown = 0;
    for (int j = 0; j < 3; j++) begin
      drive_cycle(1'b0, 1'b0, 32'h0);
      check($sformatf("post_reset_bubble_c%0d", j), ifid_valid, 32'd0);
      finish_cycle();
    end
    drive_cycle(1'b0, 1'b0, 32'h0);
    check("post_reset_c3_valid", ifid_valid, 32'd1);
    check("post_reset_c3_pc", ifid_pc, 32'h0);
`ifdef FETCH_BUBBLE_CNT_EN
    check("post_reset_bubble_cnt", bubble_cnt, 32'd3);
`endif
    finish_cycle();
    repeat (8) step(1'b0, 1'b0, 32'h0);
    check("post_reset_shown", shown, 32'd9);

    // Redirect to 0x200 with 1-cycle memory; bubble counter saturation.
    step(1'b0, 1'b1, 32'h0000_0200);
    drive_cycle(1'b0, 1'b0, 32'h0);
    check("sat_R+1_ifid_valid", ifid_valid, 32'd0);
`ifdef FETCH_BUBBLE_CNT_EN
    force dut.bubble_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_q;
`endif
    finish_cycle();
    drive_cycle(1'b0, 1'b0, 32'h0);
    check("sat_R+2_ifid_valid", ifid_valid, 32'd0);
`ifdef FETCH_BUBBLE_CNT_EN
    check("bubble_cnt_reach_max", bubble_cnt, 32'hFFFF_FFFF);
`endif
    finish_cycle();
    drive_cycle(1'b0, 1'b0, 32'h0);
    check("sat_R+3_ifid_valid", ifid_valid, 32'd0);
`ifdef FETCH_BUBBLE_CNT_EN
    check("bubble_cnt_saturated_1", bubble_cnt, 32'hFFFF_FFFF);
`endif
    finish_cycle();
    drive_cycle(1'b0, 1'b0, 32'h0);
    check("sat_R+4_ifid_valid", ifid_valid, 32'd1);
    check("sat_R+4_ifid_pc", ifid_pc, 32'h0000_0200);
`ifdef FETCH_BUBBLE_CNT_EN
    check("bubble_cnt_saturated_2", bubble_cnt, 32'hFFFF_FFFF);
`endif
    finish_cycle();

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
